// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
// Op and state codes live here so the top module and the bench agree on them.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MSUB  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL    = 3'd1,
    ST_DIV    = 3'd2,
    ST_FIXUP  = 3'd3,
    ST_COMMIT = 3'd4
  } mdu_state_e;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_mt(input mdu_op_e op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // quo_in doubles as the dividend shift register; its MSB is the next bit down
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, divisor});
  assign rem_out = fits ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MADD/MSUB engine feeding the HI/LO register pair;
// HI/LO pass straight through except in the single commit cycle or an MTHI/MTLO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITER  = MDU_ITER
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] HI_cur,
  input  logic [WIDTH-1:0] LO_cur,
  output logic [WIDTH-1:0] HI_next,
  output logic [WIDTH-1:0] LO_next,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  mdu_state_e      state_reg;
  mdu_op_e         op_reg;
  logic [CW-1:0]   cnt_reg;
  logic            sign_a_reg;
  logic            sign_b_reg;
  logic            b_zero_reg;
  logic [WIDTH-1:0] oper_reg;
  logic [WIDTH-1:0] acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic [WIDTH-1:0] res_hi_reg;
  logic [WIDTH-1:0] res_lo_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            dbz_reg;

  mdu_op_e          op_in;
  logic             in_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             mt_accept;

  assign op_in     = mdu_op_e'(Op);
  assign in_signed = op_is_signed(op_in);
  assign a_neg     = in_signed & A[WIDTH-1];
  assign b_neg     = in_signed & B[WIDTH-1];
  assign a_mag     = a_neg ? (~A + 1'b1) : A;
  assign b_mag     = b_neg ? (~B + 1'b1) : B;
  assign mt_accept = Start && (state_reg == ST_IDLE) && op_is_mt(op_in);

  // Shift-add multiply: acc_hi holds the running upper half, acc_lo the
  // multiplier that is shifted out LSB-first as product bits shift in.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, oper_reg} : '0);

  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc_hi_reg),
    .quo_in  (acc_lo_reg),
    .divisor (oper_reg),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_signed;
  logic [2*WIDTH-1:0] hilo_cur;
  logic [2*WIDTH-1:0] mac_result;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign prod_mag    = {acc_hi_reg, acc_lo_reg};
  assign prod_signed = (sign_a_reg ^ sign_b_reg) ? (~prod_mag + 1'b1) : prod_mag;
  assign hilo_cur    = {HI_cur, LO_cur};
  assign mac_result  = (op_reg == OP_MSUB) ? (hilo_cur - prod_signed) : (hilo_cur + prod_signed);
  // Truncating division: remainder follows the dividend's sign
  assign quo_fix     = (sign_a_reg ^ sign_b_reg) ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
  assign rem_fix     = sign_a_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;

  always_comb begin
    fix_hi = prod_signed[2*WIDTH-1:WIDTH];
    fix_lo = prod_signed[WIDTH-1:0];
    case (op_reg)
      OP_MADD, OP_MSUB: begin
        fix_hi = mac_result[2*WIDTH-1:WIDTH];
        fix_lo = mac_result[WIDTH-1:0];
      end
      OP_DIV, OP_DIVU: begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg  <= ST_IDLE;
      op_reg     <= OP_MULT;
      cnt_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      b_zero_reg <= 1'b0;
      oper_reg   <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      res_hi_reg <= '0;
      res_lo_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (Start && !op_is_mt(op_in)) begin
            op_reg     <= op_in;
            sign_a_reg <= a_neg;
            sign_b_reg <= b_neg;
            b_zero_reg <= op_is_div(op_in) && (B == '0);
            cnt_reg    <= '0;
            acc_hi_reg <= '0;
            busy_reg   <= 1'b1;
            if (op_is_div(op_in)) begin
              oper_reg   <= b_mag;
              acc_lo_reg <= a_mag;
              state_reg  <= ST_DIV;
            end else begin
              oper_reg   <= a_mag;
              acc_lo_reg <= b_mag;
              state_reg  <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          acc_hi_reg <= mul_sum[WIDTH:1];
          acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_FIXUP;
          end
        end
        ST_DIV: begin
          acc_hi_reg <= div_rem;
          acc_lo_reg <= div_quo;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          res_hi_reg <= fix_hi;
          res_lo_reg <= fix_lo;
          done_reg   <= 1'b1;
          dbz_reg    <= b_zero_reg;
          state_reg  <= ST_COMMIT;
        end
        ST_COMMIT: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // HI/LO registers capture every edge, so anything not committing must echo them
  always_comb begin
    HI_next = HI_cur;
    LO_next = LO_cur;
    if ((state_reg == ST_COMMIT) && !dbz_reg) begin
      HI_next = res_hi_reg;
      LO_next = res_lo_reg;
    end else if (mt_accept) begin
      if (op_in == OP_MTHI) HI_next = A;
      else                  LO_next = A;
    end
  end

  assign Busy      = busy_reg;
  assign Done      = done_reg;
  assign DivByZero = dbz_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a behavioural HI/LO register pair and a
// scoreboard of expected commit values computed from 64-bit arithmetic.
module tb_mult_div_unit;

  localparam logic [2:0] T_MULT  = 3'b000;
  localparam logic [2:0] T_MULTU = 3'b001;
  localparam logic [2:0] T_DIV   = 3'b010;
  localparam logic [2:0] T_DIVU  = 3'b011;
  localparam logic [2:0] T_MADD  = 3'b100;
  localparam logic [2:0] T_MSUB  = 3'b101;
  localparam logic [2:0] T_MTHI  = 3'b110;
  localparam logic [2:0] T_MTLO  = 3'b111;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] HI_next, LO_next;
  logic        Busy, Done, DivByZero;
  logic [31:0] hi_reg = '0;
  logic [31:0] lo_reg = '0;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  always #5 Clk = ~Clk;

  // Stand-in for HI_LO_Registers: captures every edge, untouched by Reset
  always @(posedge Clk) begin
    hi_reg <= HI_next;
    lo_reg <= LO_next;
  end

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .HI_cur    (hi_reg),
    .LO_cur    (lo_reg),
    .HI_next   (HI_next),
    .LO_next   (LO_next),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo);
    exp_t        e;
    longint      sa, sb, sp, q, r;
    logic [63:0] p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sp = sa * sb;
    acc = {hi, lo};
    e.hi = hi;
    e.lo = lo;
    e.dbz = 1'b0;
    case (op)
      T_MULT:  begin p = sp; e.hi = p[63:32]; e.lo = p[31:0]; end
      T_MULTU: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      T_MADD:  begin p = acc + sp; e.hi = p[63:32]; e.lo = p[31:0]; end
      T_MSUB:  begin p = acc - sp; e.hi = p[63:32]; e.lo = p[31:0]; end
      T_DIV, T_DIVU: begin
        if (b == 32'd0) begin
          e.dbz = 1'b1;
        end else begin
          if (op == T_DIVU) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
          end
          q = sa / sb;
          r = sa % sb;
          p = q; e.lo = p[31:0];
          p = r; e.hi = p[31:0];
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Issues one iterative op, optionally pokes Start mid-flight, and checks the commit
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    exp_t e;
    int   busy_cnt;
    int   done_at;
    sb_q.push_back(model(op, a, b, hi_reg, lo_reg));
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1 Start = 1'b0;
    busy_cnt = 0;
    done_at = -1;
    e = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge Clk);
      if (inject && k == 5) begin
        Start = 1'b1; Op = T_MTHI; A = 32'h5555_5555;
        #1 chk({tag, "_mthi_ignored"}, {32'd0, HI_next}, {32'd0, hi_reg});
      end
      if (inject && k == 6) begin
        Start = 1'b1; Op = T_DIVU; A = 32'd100; B = 32'd0;
      end
      if (inject && k == 7) Start = 1'b0;
      if (Busy) busy_cnt++;
      if (Done) begin
        done_at = k;
        e = sb_q.pop_front();
        chk({tag, "_hi_next"}, {32'd0, HI_next}, {32'd0, e.hi});
        chk({tag, "_lo_next"}, {32'd0, LO_next}, {32'd0, e.lo});
        chk({tag, "_dbz"}, {63'd0, DivByZero}, {63'd0, e.dbz});
      end
      if (!Busy) break;
    end
    if (done_at < 0 && sb_q.size() > 0) e = sb_q.pop_front();
    chk({tag, "_done_cycle"}, 64'(done_at), 64'd34);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd34);
    chk({tag, "_hilo"}, {hi_reg, lo_reg}, {e.hi, e.lo});
    $display("op %s A=%h B=%h -> HI=%h LO=%h", tag, a, b, hi_reg, lo_reg);
  endtask

  task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] a);
    logic [31:0] exp_hi, exp_lo;
    exp_hi = (op == T_MTHI) ? a : hi_reg;
    exp_lo = (op == T_MTLO) ? a : lo_reg;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a;
    #1 chk({tag, "_comb"}, {HI_next, LO_next}, {exp_hi, exp_lo});
    @(posedge Clk);
    #1 Start = 1'b0;
    chk({tag, "_busy"}, {63'd0, Busy}, 64'd0);
    chk({tag, "_hilo"}, {hi_reg, lo_reg}, {exp_hi, exp_lo});
    $display("op %s A=%h -> HI=%h LO=%h", tag, a, hi_reg, lo_reg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] saved_hi, saved_lo;

    repeat (2) @(negedge Clk);
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_done", {63'd0, Done}, 64'd0);
    chk("reset_dbz", {63'd0, DivByZero}, 64'd0);
    chk("reset_pass", {HI_next, LO_next}, {hi_reg, lo_reg});
    Reset = 1'b0;

    mt_op("mthi_pre", T_MTHI, 32'h1111_1111);
    mt_op("mtlo_pre", T_MTLO, 32'h2222_2222);
    run_op("divu_by0", T_DIVU, 32'd5, 32'd0, 1'b0);

    run_op("mult_neg", T_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    run_op("multu_ff", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mult_ff", T_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div_neg7", T_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_7_2", T_DIVU, 32'd7, 32'd2, 1'b0);
    run_op("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div_negb", T_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);

    mt_op("mthi_zero", T_MTHI, 32'h0000_0000);
    mt_op("mtlo_ones", T_MTLO, 32'hFFFF_FFFF);
    run_op("madd_1_1", T_MADD, 32'd1, 32'd1, 1'b0);
    run_op("msub_1_1", T_MSUB, 32'd1, 32'd1, 1'b0);
    run_op("msub_neg", T_MSUB, 32'hFFFF_FFFD, 32'd5, 1'b0);
    mt_op("mthi_dead", T_MTHI, 32'hDEAD_BEEF);

    // Abort a multiply during its 10th iteration cycle
    saved_hi = hi_reg;
    saved_lo = lo_reg;
    @(negedge Clk);
    Start = 1'b1; Op = T_MULT; A = 32'd7; B = 32'd9;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (9) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    chk("abort_done", {63'd0, Done}, 64'd0);
    chk("abort_dbz", {63'd0, DivByZero}, 64'd0);
    chk("abort_pass", {HI_next, LO_next}, {hi_reg, lo_reg});
    @(posedge Clk);
    #1 Reset = 1'b0;
    chk("abort_hilo_kept", {hi_reg, lo_reg}, {saved_hi, saved_lo});
    $display("op abort_mult HI=%h LO=%h", hi_reg, lo_reg);

    run_op("mult_3_5", T_MULT, 32'd3, 32'd5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
